// File: rtl/switch_debouncer.sv
// Go Board direction-switch front end: 2-flop sync, per-switch debounce and
// step-pulse FSM with optional hold-to-repeat. Four identical, independent channels.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_RATE     = 2500000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] i_switch,
  output logic [3:0] switch_stable,
  output logic [3:0] step,
  output logic       any_step
);

  localparam int DW  = ($clog2(DEBOUNCE_CYCLES + 1) > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int RDW = $clog2(REPEAT_DELAY + 1);
  localparam int RRW = $clog2(REPEAT_RATE + 1);
  localparam int HWR = (RDW > RRW) ? RDW : RRW;
  localparam int HW  = (HWR > 1) ? HWR : 1;

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] RD_LAST = HW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [HW-1:0] RR_LAST = HW'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);
  localparam logic          REPEAT_EN = (REPEAT_DELAY != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HELD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 4'b0;
      r_sync2 <= 4'b0;
    end else begin
      r_sync1 <= i_switch;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_chan
    logic          r_stable;
    logic [DW-1:0] r_db_cnt;
    state_t        r_state;
    logic [HW-1:0] r_hold_cnt;
    logic          r_step;
    logic          w_sync;

    assign w_sync = r_sync2[g];

    // Any cycle where sync agrees with the stable level restarts the count,
    // so a glitch shorter than DEBOUNCE_CYCLES never gets through.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_stable <= 1'b0;
        r_db_cnt <= '0;
      end else if (w_sync == r_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt >= DB_LAST) begin
        r_stable <= w_sync;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DW'(1);
      end
    end

    // Release is tested first in every state, so it beats a coincident terminal count.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_state    <= S_IDLE;
        r_hold_cnt <= '0;
        r_step     <= 1'b0;
      end else begin
        r_step <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (r_stable) begin
              r_state    <= S_HELD;
              r_hold_cnt <= '0;
            end
          end
          S_HELD: begin
            if (!r_stable) begin
              r_step  <= 1'b1;
              r_state <= S_IDLE;
            end else if (REPEAT_EN && (r_hold_cnt >= RD_LAST)) begin
              r_step     <= 1'b1;
              r_state    <= S_REPEAT;
              r_hold_cnt <= '0;
            end else if (REPEAT_EN) begin
              r_hold_cnt <= r_hold_cnt + HW'(1);
            end
          end
          S_REPEAT: begin
            if (!r_stable) begin
              r_state <= S_IDLE;
            end else if (r_hold_cnt >= RR_LAST) begin
              r_step     <= 1'b1;
              r_hold_cnt <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + HW'(1);
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
          end
        endcase
      end
    end

    assign switch_stable[g] = r_stable;
    assign step[g]          = r_step;
  end

  assign any_step = |step;

endmodule

// File: tb/tb_switch_debouncer.sv
// Drives three differently parameterised debouncers with shared switch stimulus and
// compares every cycle against a timestamp-based model of the debounce/step rules.
module tb_switch_debouncer;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] i_switch = 4'b0;

  logic [3:0] stable_a, step_a, stable_b, step_b, stable_c, step_c;
  logic       any_a, any_b, any_c;

  always #5 clock = ~clock;

  switch_debouncer #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_RATE(1)) u_a (
    .clock(clock), .reset_n(reset_n), .i_switch(i_switch),
    .switch_stable(stable_a), .step(step_a), .any_step(any_a));
  switch_debouncer #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(5)) u_b (
    .clock(clock), .reset_n(reset_n), .i_switch(i_switch),
    .switch_stable(stable_b), .step(step_b), .any_step(any_b));
  switch_debouncer #(.DEBOUNCE_CYCLES(1), .REPEAT_DELAY(1), .REPEAT_RATE(1)) u_c (
    .clock(clock), .reset_n(reset_n), .i_switch(i_switch),
    .switch_stable(stable_c), .step(step_c), .any_step(any_c));

  wire [26:0] obs_v = {any_c, step_c, stable_c, any_b, step_b, stable_b, any_a, step_a, stable_a};

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  int P_DEB [3] = '{4, 4, 1};
  int P_RD  [3] = '{0, 10, 1};
  int P_RR  [3] = '{1, 5, 1};

  // Model state: sampled raw history, debounced level, time the sync level started
  // disagreeing with it, time the step logic saw the press, and the step output.
  logic [3:0] m_d1 [3];
  logic [3:0] m_d2 [3];
  logic [3:0] m_stb [3];
  logic [3:0] m_seen_prev [3];
  logic [3:0] m_step [3];
  int         m_dstart [3][4];
  int         m_h [3][4];
  int         mt = 0;
  logic [26:0] exp_v = '0;

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_d1[k] = 4'b0; m_d2[k] = 4'b0; m_stb[k] = 4'b0;
      m_seen_prev[k] = 4'b0; m_step[k] = 4'b0;
      for (int c = 0; c < 4; c++) begin
        m_dstart[k][c] = -1;
        m_h[k][c] = 0;
      end
    end
    exp_v = '0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        model_clear();
      end else begin
        mt++;
        for (int k = 0; k < 3; k++) begin
          for (int c = 0; c < 4; c++) begin
            logic seen;
            logic sync_v;
            seen = m_stb[k][c];
            m_step[k][c] = 1'b0;
            if (seen && !m_seen_prev[k][c])
              m_h[k][c] = mt;
            else if (seen && P_RD[k] != 0 && mt >= m_h[k][c] + P_RD[k] &&
                     ((mt - m_h[k][c] - P_RD[k]) % P_RR[k]) == 0)
              m_step[k][c] = 1'b1;
            else if (!seen && m_seen_prev[k][c] &&
                     (P_RD[k] == 0 || mt <= m_h[k][c] + P_RD[k]))
              m_step[k][c] = 1'b1;
            m_seen_prev[k][c] = seen;

            sync_v = m_d2[k][c];
            m_d2[k][c] = m_d1[k][c];
            m_d1[k][c] = i_switch[c];
            if (sync_v == m_stb[k][c]) begin
              m_dstart[k][c] = -1;
            end else begin
              if (m_dstart[k][c] < 0) m_dstart[k][c] = mt;
              if (mt - m_dstart[k][c] + 1 == P_DEB[k]) begin
                m_stb[k][c] = sync_v;
                m_dstart[k][c] = -1;
              end
            end
          end
          for (int c = 0; c < 4; c++) begin
            exp_v[k*9 + c]     = m_stb[k][c];
            exp_v[k*9 + 4 + c] = m_step[k][c];
          end
          exp_v[k*9 + 8] = |m_step[k];
        end
      end
    end
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_switch = 4'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (obs_v !== 27'd0) begin
        n_bad++;
        $display("FAIL reset_state cyc=%0d got=%h want=0", cyc, obs_v);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_tap();
    int raw_c, rise_c, fall_c, pulses, pulse_c, any_cnt;
    rise_c = -1; fall_c = -1; pulses = 0; pulse_c = -1; any_cnt = 0;
    i_switch = 4'b0001;
    raw_c = cyc;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) i_switch = 4'b0000;
      tick();
      n_vec++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL tap_model cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
      end
      if (stable_a[0] && rise_c < 0) rise_c = cyc;
      if (!stable_a[0] && rise_c >= 0 && fall_c < 0) fall_c = cyc;
      if (step_a[0]) begin pulses++; pulse_c = cyc; end
      if (any_a) any_cnt++;
    end
    n_vec++;
    if (rise_c - raw_c !== 6) begin
      n_bad++;
      $display("FAIL tap_latency got=%0d want=6", rise_c - raw_c);
    end
    n_vec++;
    if (pulses !== 1 || any_cnt !== 1 || pulse_c !== fall_c + 1) begin
      n_bad++;
      $display("FAIL tap_step pulses=%0d any=%0d at=%0d want 1,1 at %0d", pulses, any_cnt, pulse_c, fall_c + 1);
    end
  endtask

  task automatic test_glitch();
    int seen_any;
    seen_any = 0;
    i_switch = 4'b0100;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) i_switch = 4'b0000;
      tick();
      n_vec++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL glitch_model cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
      end
      if (stable_a[2] || stable_b[2] || step_a[2] || step_b[2]) seen_any++;
    end
    n_vec++;
    if (seen_any !== 0) begin
      n_bad++;
      $display("FAIL glitch_blocked got=%0d active cycles want=0", seen_any);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat [5];
    int pulses;
    pat = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010};
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (i < 5) i_switch = pat[i];
      else if (i == 15) i_switch = 4'b0000;
      tick();
      n_vec++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL bounce_model cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
      end
      if (step_a[1]) pulses++;
    end
    n_vec++;
    if (pulses !== 1) begin
      n_bad++;
      $display("FAIL bounce_steps got=%0d want=1", pulses);
    end
  endtask

  task automatic test_simultaneous();
    int any_cnt;
    logic [3:0] step_seen;
    any_cnt = 0;
    step_seen = 4'b0;
    i_switch = 4'b1001;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) i_switch = 4'b0000;
      tick();
      n_vec++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL simul_model cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
      end
      if (any_a) begin any_cnt++; step_seen = step_a; end
    end
    n_vec++;
    if (any_cnt !== 1 || step_seen !== 4'b1001) begin
      n_bad++;
      $display("FAIL simul_step any=%0d step=%b want 1 and 1001", any_cnt, step_seen);
    end
  endtask

  task automatic test_repeat();
    int s_c, bound, nbad_local;
    int offs [$];
    s_c = -1;
    bound = 0;
    i_switch = 4'b1000;
    while (s_c < 0 && bound < 20) begin
      tick();
      bound++;
      n_vec++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL repeat_model cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
      end
      if (stable_b[3]) s_c = cyc;
    end
    n_vec++;
    if (s_c < 0) begin
      n_bad++;
      $display("FAIL repeat_press stable_b[3]=%b want 1 within 20 cycles", stable_b[3]);
    end else begin
      while (cyc < s_c + 50) begin
        if (cyc == s_c + 27) i_switch = 4'b0000;
        tick();
        n_vec++;
        if (obs_v !== exp_v) begin
          n_bad++;
          $display("FAIL repeat_model cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
        end
        if (step_b[3]) offs.push_back(cyc - s_c);
      end
      nbad_local = (offs.size() != 5) ? 1 : 0;
      for (int k = 0; k < offs.size() && k < 5; k++)
        if (offs[k] != 11 + 5 * k) nbad_local++;
      n_vec++;
      if (nbad_local != 0) begin
        n_bad++;
        $display("FAIL repeat_times got %0d pulses first=%0d want 5 at 11,16,21,26,31",
                 offs.size(), (offs.size() > 0) ? offs[0] : -1);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int stray;
    stray = 0;
    i_switch = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_vec++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL midrst_model cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
      end
    end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (obs_v !== 27'd0) begin
      n_bad++;
      $display("FAIL midrst_async got=%h want=0", obs_v);
    end
    i_switch = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (obs_v !== 27'd0) begin
        n_bad++;
        $display("FAIL midrst_hold got=%h want=0", obs_v);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_vec++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL midrst_model cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
      end
      if (any_a || any_b || any_c) stray++;
    end
    n_vec++;
    if (stray !== 0) begin
      n_bad++;
      $display("FAIL midrst_no_step got=%0d step cycles want=0", stray);
    end
  endtask

  task automatic test_random();
    int len;
    for (int seg = 0; seg < 120; seg++) begin
      i_switch = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        tick();
        n_vec++;
        if (obs_v !== exp_v) begin
          n_bad++;
          $display("FAIL random_model cyc=%0d in=%b got=%h want=%h", cyc, i_switch, obs_v, exp_v);
        end
      end
    end
    i_switch = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL random_drain cyc=%0d got=%h want=%h", cyc, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tap();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_repeat();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
